// File: rtl/rf_wb_scheduler.sv
// Writeback write-port arbiter plus in-flight destination scoreboard for a 32x32 regfile (x0 = 0).
// Latency: a request granted in cycle N is presented on RegWEn/rd_addr/rd_data in cycle N+1.
// Backpressure: round-robin req_ready, one grant per cycle; stall holds issue on RAW/WAW hazards.
// Optional feature: define RF_FWD_EN to add commit-cycle operand forwarding outputs.
module rf_wb_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int AW      = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*AW-1:0]   req_addr,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  input  logic                    alloc_valid,
  input  logic [AW-1:0]           alloc_addr,
  input  logic [AW-1:0]           rs1_addr,
  input  logic [AW-1:0]           rs2_addr,
  output logic                    stall,
`ifdef RF_FWD_EN
  output logic                    fwd_rs1_sel,
  output logic                    fwd_rs2_sel,
  output logic [XLEN-1:0]         fwd_rs1_data,
  output logic [XLEN-1:0]         fwd_rs2_data,
`endif
  output logic                    RegWEn,
  output logic [AW-1:0]           rd_addr,
  output logic [XLEN-1:0]         rd_data
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int NR = 1 << AW;

  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      gidx;
  logic               found;
  logic [NUM_REQ-1:0] grant;
  logic [AW-1:0]      gaddr;
  logic [XLEN-1:0]    gdata;
  logic [NR-1:0]      busy;
  logic [NR-1:0]      busy_nxt;
  logic               alloc_set;
  logic               rs1_hit;
  logic               rs2_hit;

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gidx  = IW'(idx);
      end
    end
    if (found) grant[gidx] = 1'b1;
  end

  assign gaddr     = req_addr[gidx*AW +: AW];
  assign gdata     = req_data[gidx*XLEN +: XLEN];
  // Grants are forced low while reset is asserted so nothing is consumed then.
  assign req_ready = grant & {NUM_REQ{rst_n}};

  // Pointer advance and registered write port; x0 writes are consumed but never enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      RegWEn  <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
    end else if (found) begin
      rr_ptr <= IW'((int'(gidx) + 1) % NUM_REQ);
      RegWEn <= (gaddr != '0);
      if (gaddr != '0) begin
        rd_addr <= gaddr;
        rd_data <= gdata;
      end
    end else begin
      RegWEn <= 1'b0;
    end
  end

`ifdef RF_FWD_EN
  assign rs1_hit      = RegWEn && (rd_addr == rs1_addr) && (rs1_addr != '0);
  assign rs2_hit      = RegWEn && (rd_addr == rs2_addr) && (rs2_addr != '0);
  assign fwd_rs1_sel  = rs1_hit;
  assign fwd_rs2_sel  = rs2_hit;
  assign fwd_rs1_data = rs1_hit ? rd_data : '0;
  assign fwd_rs2_data = rs2_hit ? rd_data : '0;
`else
  assign rs1_hit = 1'b0;
  assign rs2_hit = 1'b0;
`endif

  // A forwarded source is satisfied in the commit cycle; the WAW check is never bypassed.
  assign stall = (busy[rs1_addr] & ~rs1_hit) | (busy[rs2_addr] & ~rs2_hit) |
                 (alloc_valid & busy[alloc_addr]);

  assign alloc_set = alloc_valid && !stall && (alloc_addr != '0);

  // Scoreboard update: commit clears, allocation sets afterwards so set wins on a collision.
  always_comb begin
    busy_nxt = busy;
    if (RegWEn) busy_nxt[rd_addr] = 1'b0;
    if (alloc_set) busy_nxt[alloc_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
module tb_rf_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic        alloc_valid;
  logic [4:0]  alloc_addr, rs1_addr, rs2_addr;
  logic        stall, RegWEn;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
`ifdef RF_FWD_EN
  logic        fwd_rs1_sel, fwd_rs2_sel;
  logic [31:0] fwd_rs1_data, fwd_rs2_data;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rf_wb_scheduler #(.NUM_REQ(2), .XLEN(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .stall(stall),
`ifdef RF_FWD_EN
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
`endif
    .RegWEn(RegWEn), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  typedef struct {
    logic [1:0]  rv;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic        av;
    logic [4:0]  aa, r1, r2;
    logic [1:0]  rdy;
    logic        st;   // expected stall without forwarding
    logic        stf;  // expected stall with forwarding
  } vec_t;

  typedef struct packed {
    logic        wen;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  vec_t tbl[29];
  wr_t  sb[$];

  function automatic vec_t mk(logic [1:0] rv, logic [4:0] a0, logic [4:0] a1,
                              logic [31:0] d0, logic [31:0] d1, logic av,
                              logic [4:0] aa, logic [4:0] r1, logic [4:0] r2,
                              logic [1:0] rdy, logic st, logic stf);
    vec_t v;
    v.rv = rv; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.av = av;
    v.aa = aa; v.r1 = r1; v.r2 = r2; v.rdy = rdy; v.st = st; v.stf = stf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Compare the write port against the oldest scoreboard entry (one entry per cycle).
  task automatic check_port(input string nm);
    wr_t e;
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    chk({nm, ".RegWEn"}, 32'(RegWEn), 32'(e.wen));
    if (e.wen) begin
      chk({nm, ".rd_addr"}, 32'(rd_addr), 32'(e.a));
      chk({nm, ".rd_data"}, rd_data, e.d);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    wr_t e;
    logic exp_st;
    @(negedge clk);
    req_valid = v.rv; req_addr = {v.a1, v.a0}; req_data = {v.d1, v.d0};
    alloc_valid = v.av; alloc_addr = v.aa; rs1_addr = v.r1; rs2_addr = v.r2;
    #1;
`ifdef RF_FWD_EN
    exp_st = v.stf;
`else
    exp_st = v.st;
`endif
    chk({nm, ".ready"}, 32'(req_ready), 32'(v.rdy));
    chk({nm, ".stall"}, 32'(stall), 32'(exp_st));
    check_port(nm);
    e = '0;
    if (v.rdy[1]) begin
      e.a = v.a1; e.d = v.d1; e.wen = (v.a1 != 5'd0);
    end else if (v.rdy[0]) begin
      e.a = v.a0; e.d = v.d0; e.wen = (v.a0 != 5'd0);
    end
    sb.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    alloc_valid = 1'b0; alloc_addr = '0; rs1_addr = '0; rs2_addr = '0;

    // contention, round-robin, idle hold
    tbl[0]  = mk(2'b11, 3, 4, 32'hA0, 32'hB0, 0, 0, 0, 0, 2'b01, 0, 0);
    tbl[1]  = mk(2'b11, 3, 4, 32'hA1, 32'hB1, 0, 0, 0, 0, 2'b10, 0, 0);
    tbl[2]  = mk(2'b11, 3, 4, 32'hA2, 32'hB2, 0, 0, 0, 0, 2'b01, 0, 0);
    tbl[3]  = mk(2'b11, 3, 4, 32'hA3, 32'hB3, 0, 0, 0, 0, 2'b10, 0, 0);
    tbl[4]  = mk(2'b00, 3, 4, 32'hA4, 32'hB4, 0, 0, 0, 0, 2'b00, 0, 0);
    tbl[5]  = mk(2'b10, 3, 4, 32'hA4, 32'hB4, 0, 0, 0, 0, 2'b10, 0, 0);
    tbl[6]  = mk(2'b01, 3, 4, 32'hA5, 32'hB5, 0, 0, 0, 0, 2'b01, 0, 0);
    tbl[7]  = mk(2'b01, 3, 4, 32'hA6, 32'hB5, 0, 0, 0, 0, 2'b01, 0, 0);
    // RAW on x7
    tbl[8]  = mk(2'b00, 0, 0, 0, 0, 1, 7, 0, 0, 2'b00, 0, 0);
    tbl[9]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 7, 0, 2'b00, 1, 1);
    tbl[10] = mk(2'b01, 7, 0, 32'hC7, 0, 0, 0, 7, 0, 2'b01, 1, 1);
    tbl[11] = mk(2'b00, 0, 0, 0, 0, 0, 0, 7, 0, 2'b00, 1, 0);
    tbl[12] = mk(2'b00, 0, 0, 0, 0, 0, 0, 7, 0, 2'b00, 0, 0);
    // WAW on x7, then RAW via rs2
    tbl[13] = mk(2'b00, 0, 0, 0, 0, 1, 7, 0, 0, 2'b00, 0, 0);
    tbl[14] = mk(2'b00, 0, 0, 0, 0, 1, 7, 0, 0, 2'b00, 1, 1);
    tbl[15] = mk(2'b01, 7, 0, 32'hC8, 0, 0, 0, 0, 7, 2'b01, 1, 1);
    tbl[16] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 7, 2'b00, 1, 0);
    tbl[17] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 7, 2'b00, 0, 0);
    // x0 write and x0 alloc
    tbl[18] = mk(2'b10, 0, 0, 0, 32'hDEAD, 0, 0, 0, 0, 2'b10, 0, 0);
    tbl[19] = mk(2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0);
    tbl[20] = mk(2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0);
    tbl[21] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    // set/clear race on x9
    tbl[22] = mk(2'b01, 9, 0, 32'hD9, 0, 0, 0, 0, 0, 2'b01, 0, 0);
    tbl[23] = mk(2'b00, 0, 0, 0, 0, 1, 9, 0, 0, 2'b00, 0, 0);
    tbl[24] = mk(2'b00, 0, 0, 0, 0, 0, 0, 9, 0, 2'b00, 1, 1);
    tbl[25] = mk(2'b00, 0, 0, 0, 0, 0, 0, 9, 0, 2'b00, 1, 1);
    tbl[26] = mk(2'b01, 9, 0, 32'hE9, 0, 0, 0, 9, 0, 2'b01, 1, 1);
    tbl[27] = mk(2'b00, 0, 0, 0, 0, 0, 0, 9, 0, 2'b00, 1, 0);
    tbl[28] = mk(2'b00, 0, 0, 0, 0, 0, 0, 9, 0, 2'b00, 0, 0);

    // reset state
    repeat (2) @(negedge clk);
    req_valid = 2'b11; #1;
    chk("rst.ready", 32'(req_ready), 0);
    chk("rst.RegWEn", 32'(RegWEn), 0);
    chk("rst.rd_addr", 32'(rd_addr), 0);
    chk("rst.rd_data", rd_data, 0);
    chk("rst.stall", 32'(stall), 0);
    req_valid = '0;
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 29; i++) apply(tbl[i], $sformatf("v%0d", i));

    // reset in the middle of a commit with busy[5] set
    apply(mk(2'b00, 0, 0, 0, 0, 1, 5, 0, 0, 2'b00, 0, 0), "t1a");
    apply(mk(2'b01, 5, 0, 32'h55, 0, 0, 0, 5, 0, 2'b01, 1, 1), "t1b");
    @(negedge clk);
    req_valid = 2'b00; alloc_valid = 1'b1; alloc_addr = 5'd5; rs1_addr = 5'd0;
    #1;
    chk("t1c.stall", 32'(stall), 1);
    check_port("t1c");
    req_valid = 2'b01; req_addr = 10'd5;
    #1 rst_n = 1'b0;
    #1;
    chk("t1d.RegWEn", 32'(RegWEn), 0);
    chk("t1d.rd_addr", 32'(rd_addr), 0);
    chk("t1d.stall", 32'(stall), 0);
    chk("t1d.ready", 32'(req_ready), 0);
    sb.delete();
    @(negedge clk);
    req_valid = '0; alloc_valid = 1'b0; rs1_addr = 5'd5;
    rst_n = 1'b1;
    #1;
    chk("t1e.stall", 32'(stall), 0);
    check_port("t1e");

`ifdef RF_FWD_EN
    apply(mk(2'b00, 0, 0, 0, 0, 1, 12, 0, 0, 2'b00, 0, 0), "t6a");
    apply(mk(2'b01, 12, 0, 32'h1234, 0, 0, 0, 0, 12, 2'b01, 1, 1), "t6b");
    @(negedge clk);
    req_valid = '0; rs2_addr = 5'd12; rs1_addr = 5'd0;
    #1;
    chk("t6.stall", 32'(stall), 0);
    chk("t6.fwd_rs2_sel", 32'(fwd_rs2_sel), 1);
    chk("t6.fwd_rs2_data", fwd_rs2_data, 32'h1234);
    chk("t6.fwd_rs1_sel", 32'(fwd_rs1_sel), 0);
    check_port("t6");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
